top_tdr_creation_tessent_tdr_mux_ctrl: RTL and testbench
========================================================

TOP_TDR_CREATION_TESSENT_TDR_MUX_CTRL -- requirements
Module: top_tdr_creation_tessent_tdr_mux_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, which sets the width of the mux-control data field.
REQ-002 SHALL have port ijtag_tck, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL have port ijtag_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ijtag_sel, input, 1 bit: TDR selected on the active scan path.
REQ-005 SHALL have port ijtag_ce, input, 1 bit: capture enable.
REQ-006 SHALL have port ijtag_se, input, 1 bit: shift enable.
REQ-007 SHALL have port ijtag_ue, input, 1 bit: update enable.
REQ-008 SHALL have port ijtag_si, input, 1 bit: scan in.
REQ-009 SHALL have port ijtag_so, output, 1 bit: scan out, equal to shift-register bit 0.
REQ-010 SHALL have port observe_data, input, DATA_WIDTH bits: the downstream data-mux output, captured for observation.
REQ-011 SHALL have port ijtag_select, output, 1 bit: drives the downstream mux ijtag_select.
REQ-012 SHALL have port ijtag_data_out, output, DATA_WIDTH bits: drives the downstream mux ijtag_data_in.
REQ-013 SHALL have port length_err, output, 1 bit: sticky update-rejected flag.

Function
REQ-014 SHALL hold a shift register sr of DATA_WIDTH+1 bits: sr[DATA_WIDTH] is the select bit and sr[DATA_WIDTH-1:0] is the data field.
REQ-015 SHALL hold the update registers upd_sel (1 bit) and upd_data (DATA_WIDTH bits); ijtag_select = upd_sel and ijtag_data_out = upd_data, both driven directly from flops.
REQ-016 SHALL ignore ce, se and ue while ijtag_sel=0 (all state is held).
REQ-017 Capture: on a clock edge with sel=1 and ce=1, SHALL load sr <= {upd_sel, observe_data}.
REQ-018 Shift: on a clock edge with sel=1, se=1 and ce=0, SHALL load sr <= {ijtag_si, sr[DATA_WIDTH:1]}, so the LSB exits on ijtag_so first.
REQ-019 Update: on a clock edge with sel=1 and ue=1 (and the update accepted per REQ-025), SHALL load {upd_sel, upd_data} <= sr as it was before that edge.
REQ-020 Simultaneous ce and se: capture SHALL win and no shift occurs; ue SHALL act independently on the pre-edge sr.
REQ-021 Latency: an update SHALL be visible on ijtag_select and ijtag_data_out one cycle after the ue edge.
REQ-022 SHALL keep a shift counter cnt, sized clog2(DATA_WIDTH+3) bits: cleared on capture, incremented on each shift, saturating at DATA_WIDTH+2.

Reset
REQ-023 While ijtag_reset=1 SHALL asynchronously force sr=0, upd_sel=0, upd_data=0, cnt=0 and length_err=0; therefore ijtag_select=0 (functional path selected) and ijtag_so=0.
REQ-024 Reset asserted mid-shift SHALL discard the partial load; after release the next update applies only what was shifted after release, with cnt counted from 0.

Configuration
REQ-025 With TDR_LENGTH_CHECK_EN defined: an update SHALL be accepted only when cnt == DATA_WIDTH+1; otherwise the update registers hold and length_err is set. An accepted update SHALL clear length_err. cnt SHALL clear after any update edge.
REQ-026 Without TDR_LENGTH_CHECK_EN: every update SHALL be accepted, length_err SHALL be tied 0, and the cnt logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the default DATA_WIDTH constant, the bit-index constants for the select and data fields within sr, and a function computing the counter width.
REQ-028 Shift/capture/update SHALL be implemented in one sub-module top_tdr_creation_tessent_tdr_shift_upd; the length checker and output wiring SHALL live at top level.

Verification (DATA_WIDTH=2, TDR_LENGTH_CHECK_EN defined unless stated)
REQ-029 Reset then idle: ijtag_select=0, ijtag_data_out=2'b00, ijtag_so=0, length_err=0.
REQ-030 Capture, then shift si bits 0,1,1 (first to last), then ue: sr=3'b110, so ijtag_select=1 and ijtag_data_out=2'b10 one cycle after ue.
REQ-031 observe_data=2'b01 with upd_sel=1, then capture, then shift 3 bits: ijtag_so emits 1,0,1.
REQ-032 Capture, shift only 2 bits, then ue: outputs unchanged and length_err=1; a following correct 3-bit load clears length_err.
REQ-033 ce=se=1 on the same edge: sr equals the captured value (no shift) and cnt=0; any signal toggled with sel=0 leaves all state unchanged.
REQ-034 Macro undefined: a 2-bit shift followed by ue updates the outputs; length_err stays 0.

Source files
------------

// File: rtl/top_tdr_creation_tessent_tdr_mux_ctrl_pkg.sv
// top_tdr_creation_tessent_tdr_mux_ctrl_pkg: shared constants and helpers for the mux-control TDR
package top_tdr_creation_tessent_tdr_mux_ctrl_pkg;
   localparam int DEFAULT_DATA_WIDTH = 2;
   localparam int DATA_LSB = 0;
   function automatic int sel_bit(input int data_width);
      return data_width;
   endfunction
   function automatic int data_msb(input int data_width);
      return data_width - 1;
   endfunction
   function automatic int cnt_width(input int data_width);
      return $clog2(data_width + 3);
   endfunction
endpackage

// File: rtl/top_tdr_creation_tessent_tdr_shift_upd.sv
// top_tdr_creation_tessent_tdr_shift_upd: capture/shift register and update stage of the mux-control TDR
module top_tdr_creation_tessent_tdr_shift_upd
   import top_tdr_creation_tessent_tdr_mux_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sel,
   input  logic                  ce,
   input  logic                  se,
   input  logic                  ue,
   input  logic                  si,
   input  logic                  upd_en,
   input  logic [DATA_WIDTH-1:0] observe_data,
   output logic                  so,
   output logic                  upd_sel,
   output logic [DATA_WIDTH-1:0] upd_data
);
   localparam int SEL = sel_bit(DATA_WIDTH);
   localparam int MSB = data_msb(DATA_WIDTH);
   logic [DATA_WIDTH:0]   sr_d, sr_q;
   logic                  upd_sel_d, upd_sel_q;
   logic [DATA_WIDTH-1:0] upd_data_d, upd_data_q;
   logic                  upd_do;
   // capture wins over shift; update always samples the pre-edge register
   always_comb begin
      upd_do     = sel && ue && upd_en;
      sr_d       = !sel ? sr_q : ce ? {upd_sel_q, observe_data} : se ? {si, sr_q[SEL:1]} : sr_q;
      upd_sel_d  = upd_do ? sr_q[SEL] : upd_sel_q;
      upd_data_d = upd_do ? sr_q[MSB:DATA_LSB] : upd_data_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q       <= '0;
         upd_sel_q  <= 1'b0;
         upd_data_q <= '0;
      end else begin
         sr_q       <= sr_d;
         upd_sel_q  <= upd_sel_d;
         upd_data_q <= upd_data_d;
      end
   end
   assign so       = sr_q[DATA_LSB];
   assign upd_sel  = upd_sel_q;
   assign upd_data = upd_data_q;
endmodule

// File: rtl/top_tdr_creation_tessent_tdr_mux_ctrl.sv
// top_tdr_creation_tessent_tdr_mux_ctrl: iJTAG TDR driving a downstream data mux select/data.
// Define TDR_LENGTH_CHECK_EN to reject updates whose shift length is not DATA_WIDTH+1.
module top_tdr_creation_tessent_tdr_mux_ctrl
   import top_tdr_creation_tessent_tdr_mux_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  ijtag_tck,
   input  logic                  ijtag_reset,
   input  logic                  ijtag_sel,
   input  logic                  ijtag_ce,
   input  logic                  ijtag_se,
   input  logic                  ijtag_ue,
   input  logic                  ijtag_si,
   output logic                  ijtag_so,
   input  logic [DATA_WIDTH-1:0] observe_data,
   output logic                  ijtag_select,
   output logic [DATA_WIDTH-1:0] ijtag_data_out,
   output logic                  length_err
);
   logic upd_en;
`ifdef TDR_LENGTH_CHECK_EN
   localparam int CW = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH + 2);
   localparam logic [CW-1:0] CNT_OK  = CW'(DATA_WIDTH + 1);
   logic [CW-1:0] cnt_d, cnt_q;
   logic          length_err_d, length_err_q;
   // any update edge restarts the count, accepted or not
   always_comb begin
      upd_en       = cnt_q == CNT_OK;
      cnt_d        = !ijtag_sel ? cnt_q : (ijtag_ue || ijtag_ce) ? '0 :
                     (ijtag_se && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
      length_err_d = (ijtag_sel && ijtag_ue) ? !upd_en : length_err_q;
   end
   always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
      if (ijtag_reset) begin
         cnt_q        <= '0;
         length_err_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         length_err_q <= length_err_d;
      end
   end
   assign length_err = length_err_q;
`else
   assign upd_en     = 1'b1;
   assign length_err = 1'b0;
`endif
   top_tdr_creation_tessent_tdr_shift_upd #(.DATA_WIDTH(DATA_WIDTH)) u_shift_upd (
      .clk         (ijtag_tck),
      .rst         (ijtag_reset),
      .sel         (ijtag_sel),
      .ce          (ijtag_ce),
      .se          (ijtag_se),
      .ue          (ijtag_ue),
      .si          (ijtag_si),
      .upd_en      (upd_en),
      .observe_data(observe_data),
      .so          (ijtag_so),
      .upd_sel     (ijtag_select),
      .upd_data    (ijtag_data_out)
   );
endmodule

// File: tb/tb_top_tdr_creation_tessent_tdr_mux_ctrl.sv
// tb_top_tdr_creation_tessent_tdr_mux_ctrl: scoreboard bench with a bit-queue reference model
module tb_top_tdr_creation_tessent_tdr_mux_ctrl;
   localparam int DW = 2;
   logic clk = 1'b0;
   logic rst, sel, ce, se, ue, si;
   logic [DW-1:0] obs;
   logic so, select_o, err_o;
   logic [DW-1:0] data_o;

   top_tdr_creation_tessent_tdr_mux_ctrl #(.DATA_WIDTH(DW)) dut (
      .ijtag_tck     (clk),
      .ijtag_reset   (rst),
      .ijtag_sel     (sel),
      .ijtag_ce      (ce),
      .ijtag_se      (se),
      .ijtag_ue      (ue),
      .ijtag_si      (si),
      .ijtag_so      (so),
      .observe_data  (obs),
      .ijtag_select  (select_o),
      .ijtag_data_out(data_o),
      .length_err    (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          s;
      logic [DW-1:0] d;
      logic          so;
      logic          err;
   } exp_t;
   exp_t q[$];
   int tests = 0;
   int fails = 0;

   bit msr[$];
   bit m_usel;
   bit [DW-1:0] m_udata;
   int m_shifted;
   bit m_err;

   function automatic void model_reset();
      msr.delete();
      for (int i = 0; i <= DW; i++) msr.push_back(1'b0);
      m_usel = 0;
      m_udata = '0;
      m_shifted = 0;
      m_err = 0;
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.s = m_usel;
      e.d = m_udata;
      e.so = msr[0];
      e.err = m_err;
      q.push_back(e);
   endfunction

   function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("select", DW'(select_o), DW'(e.s));
         chk("data_out", data_o, e.d);
         chk("so", DW'(so), DW'(e.so));
         chk("length_err", DW'(err_o), DW'(e.err));
      end
   end

   task automatic step(input bit s, input bit c, input bit h, input bit u, input bit i, input bit [DW-1:0] o);
      bit acc;
      bit old_usel;
      sel = s; ce = c; se = h; ue = u; si = i; obs = o;
      @(posedge clk);
      if (s) begin
         old_usel = m_usel;
         if (u) begin
`ifdef TDR_LENGTH_CHECK_EN
            acc = (m_shifted == DW + 1);
            m_err = !acc;
`else
            acc = 1;
`endif
            if (acc) begin
               m_usel = msr[DW];
               for (int k = 0; k < DW; k++) m_udata[k] = msr[k];
            end
         end
         if (c) begin
            msr.delete();
            for (int k = 0; k < DW; k++) msr.push_back(o[k]);
            msr.push_back(old_usel);
            m_shifted = 0;
         end else if (h) begin
            void'(msr.pop_front());
            msr.push_back(i);
            m_shifted++;
         end
         if (u) m_shifted = 0;
      end
      #1 push_exp();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1;
      model_reset();
      @(posedge clk);
      #1 push_exp();
      rst = 0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, DW'($urandom));
   endtask

   initial begin
      rst = 1; sel = 0; ce = 0; se = 0; ue = 0; si = 0; obs = '0;
      model_reset();
      do_reset();
      idle(); idle();
      step(1, 1, 0, 0, 0, DW'($urandom));
      step(1, 0, 1, 0, 0, '0);
      step(1, 0, 1, 0, 1, '0);
      step(1, 0, 1, 0, 1, '0);
      step(1, 0, 0, 1, 0, '0);
      idle();
      step(1, 1, 0, 0, 0, 2'b01);
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 1'($urandom), '0);
      idle();
      step(1, 1, 0, 0, 0, DW'($urandom));
      step(1, 0, 1, 0, 0, '0);
      step(1, 0, 1, 0, 0, '0);
      step(1, 0, 0, 1, 0, '0);
      idle();
      step(1, 1, 0, 0, 0, DW'($urandom));
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 1'($urandom), '0);
      step(1, 0, 0, 1, 0, '0);
      idle();
      step(1, 1, 1, 0, 1, 2'b10);
      step(1, 0, 0, 1, 0, '0);
      for (int k = 0; k < 6; k++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
      step(1, 1, 0, 0, 0, 2'b11);
      step(1, 0, 1, 0, 1, '0);
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 1'($urandom), '0);
      step(1, 0, 0, 1, 0, '0);
      idle();
      for (int k = 0; k < 400; k++)
         step($urandom % 4 != 0, $urandom % 6 == 0, 1'($urandom), $urandom % 5 == 0, 1'($urandom), DW'($urandom));
      idle();
      for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
